// File: rtl/mem_master_16x32.sv
// rtl/mem_master_16x32.sv - request/response master for a 16x32 synchronous-read memory
// Supports read, single write, whole-memory fill, and flags illegal ops.
module mem_master_16x32 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_in,
  output logic              mem_en_wr,
  output logic              mem_en_rd,
  input  logic [DATA_W-1:0] mem_d_out
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    FILL,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  state_t              state, state_n;
  logic                req_ready_n, rsp_valid_n, wr_done_n, err_n, busy_n;
  logic                mem_en_wr_n, mem_en_rd_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_d_in_n, rsp_rdata_n;
  logic                accept;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wr_done   <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_d_in  <= '0;
      mem_en_wr <= 1'b0;
      mem_en_rd <= 1'b0;
    end else begin
      state     <= state_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      wr_done   <= wr_done_n;
      err       <= err_n;
      busy      <= busy_n;
      mem_addr  <= mem_addr_n;
      mem_d_in  <= mem_d_in_n;
      mem_en_wr <= mem_en_wr_n;
      mem_en_rd <= mem_en_rd_n;
    end
  end

  // Every output is computed for the next state here and registered above.
  always_comb begin
    state_n     = state;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    wr_done_n   = 1'b0;
    err_n       = 1'b0;
    mem_addr_n  = mem_addr;
    mem_d_in_n  = mem_d_in;
    mem_en_wr_n = 1'b0;
    mem_en_rd_n = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (req_op)
            2'b00: begin
              state_n     = RD_ISSUE;
              mem_addr_n  = req_addr;
              mem_en_rd_n = 1'b1;
            end
            2'b01: begin
              state_n     = WR;
              mem_addr_n  = req_addr;
              mem_d_in_n  = req_wdata;
              mem_en_wr_n = 1'b1;
            end
            2'b10: begin
              state_n     = FILL;
              mem_addr_n  = '0;
              mem_d_in_n  = req_wdata;
              mem_en_wr_n = 1'b1;
            end
            default: err_n = 1'b1;
          endcase
        end
      end
      WR: begin
        state_n   = IDLE;
        wr_done_n = 1'b1;
      end
      FILL: begin
        // mem_addr doubles as the fill counter; it wraps back to 0 on exit.
        mem_addr_n = mem_addr + ADDR_W'(1);
        if (mem_addr == {ADDR_W{1'b1}}) begin
          state_n   = IDLE;
          wr_done_n = 1'b1;
        end else begin
          mem_en_wr_n = 1'b1;
        end
      end
      RD_ISSUE: begin
        state_n     = RD_WAIT;
        mem_en_rd_n = 1'b1;
      end
      RD_WAIT: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
        rsp_rdata_n = mem_d_out;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
        else rsp_valid_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    req_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mem_master_16x32.sv
// tb/tb_mem_master_16x32.sv - directed self-checking bench for mem_master_16x32
module tb_mem_master_16x32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        wr_done;
  logic        err;
  logic        busy;
  logic [3:0]  mem_addr;
  logic [31:0] mem_d_in;
  logic        mem_en_wr;
  logic        mem_en_rd;
  logic [31:0] mem_d_out;

  logic [31:0] mem [16];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mon_on  = 1'b0;

  always #5 clk = ~clk;

  mem_master_16x32 #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .wr_done   (wr_done),
    .err       (err),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_d_in  (mem_d_in),
    .mem_en_wr (mem_en_wr),
    .mem_en_rd (mem_en_rd),
    .mem_d_out (mem_d_out)
  );

  // Synchronous-read memory model: read data registered on the enable edge.
  always @(posedge clk) begin
    if (mem_en_wr) mem[mem_addr] <= mem_d_in;
    if (mem_en_rd) mem_d_out <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) check("en_exclusive", 32'(mem_en_wr & mem_en_rd), 32'd0);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_wr_done"},   32'(wr_done), 32'd0);
    check({tag, "_err"},       32'(err), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_mem_d_in"},  mem_d_in, 32'd0);
    check({tag, "_en_wr"},     32'(mem_en_wr), 32'd0);
    check({tag, "_en_rd"},     32'(mem_en_rd), 32'd0);
  endtask

  // Called at a negedge; returns just after the acceptance edge.
  task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] data);
    check("pre_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = data;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
    send(2'b01, addr, data);
    @(negedge clk);
    check("wr_en", 32'(mem_en_wr), 32'd1);
    check("wr_addr", 32'(mem_addr), 32'(addr));
    check("wr_data", mem_d_in, data);
    check("wr_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("wr_done_hi", 32'(wr_done), 32'd1);
    check("wr_en_off", 32'(mem_en_wr), 32'd0);
    check("wr_ready_back", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("wr_done_lo", 32'(wr_done), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input int stall);
    int edges;
    edges = 0;
    rsp_ready = 1'b0;
    send(2'b00, addr, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("rd_en", 32'(mem_en_rd), 32'd1);
        check("rd_addr", 32'(mem_addr), 32'(addr));
      end
      if (rsp_valid) begin
        edges = i;
        break;
      end
    end
    check("rd_latency", 32'(edges), 32'd3);
    check("rd_data", rsp_rdata, exp);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", rsp_rdata, exp);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_en_rd", 32'(mem_en_rd), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_off", 32'(rsp_valid), 32'd0);
    check("rsp_req_ready", 32'(req_ready), 32'd1);
    check("rsp_hold", rsp_rdata, exp);
    check("rsp_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_fill(input logic [31:0] pat);
    send(2'b10, 4'd0, pat);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("fill_en", 32'(mem_en_wr), 32'd1);
      check("fill_addr", 32'(mem_addr), 32'(i));
      check("fill_data", mem_d_in, pat);
      check("fill_no_done", 32'(wr_done), 32'd0);
    end
    @(negedge clk);
    check("fill_done_hi", 32'(wr_done), 32'd1);
    check("fill_en_off", 32'(mem_en_wr), 32'd0);
    @(negedge clk);
    check("fill_done_lo", 32'(wr_done), 32'd0);
    check("fill_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem_d_out = 32'd0;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 4'd5;
    req_wdata = 32'hFFFF_FFFF;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    req_valid = 1'b0;
    rst       = 1'b0;
    mon_on    = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);

    do_write(4'd3, 32'hDEAD_BEEF);
    do_read(4'd3, 32'hDEAD_BEEF, 0);

    do_fill(32'hA5A5_A5A5);
    do_read(4'd0, 32'hA5A5_A5A5, 0);
    do_read(4'd15, 32'hA5A5_A5A5, 0);

    do_read(4'd3, 32'hA5A5_A5A5, 5);

    send(2'b11, 4'd2, 32'h1111_1111);
    @(negedge clk);
    check("ill_err_hi", 32'(err), 32'd1);
    check("ill_en_wr", 32'(mem_en_wr), 32'd0);
    check("ill_en_rd", 32'(mem_en_rd), 32'd0);
    check("ill_ready", 32'(req_ready), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("ill_err_lo", 32'(err), 32'd0);
    check("ill_en_wr2", 32'(mem_en_wr), 32'd0);

    do_write(4'd8, 32'h1234_5678);

    // Fill aborted by reset at address 7; a write request is held during reset.
    send(2'b10, 4'd0, 32'h5A5A_5A5A);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_en_wr && mem_addr == 4'd7) begin
          seen = 1;
          break;
        end
      end
      check("fill_reached_7", 32'(seen), 32'd1);
    end
    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 4'd9;
    req_wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    check_reset_outputs("abort2");
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_no_accept_en", 32'(mem_en_wr), 32'd0);
    check("abort_no_accept_busy", 32'(busy), 32'd0);
    check("abort_no_done", 32'(wr_done), 32'd0);

    do_read(4'd8, 32'h1234_5678, 0);
    do_read(4'd7, 32'h5A5A_5A5A, 0);
    do_read(4'd9, 32'hA5A5_A5A5, 0);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
